// File: rtl/picorv32_irq_timer_pkg.sv
// Shared types and helpers for the picorv32 periodic interrupt timer.
// The config struct carries a full 32-bit period so it is independent of CNT_W.
package picorv32_irq_timer_pkg;

   localparam int MAX_CNT_W = 32;

   localparam logic MODE_PULSE = 1'b0;
   localparam logic MODE_LATCH = 1'b1;

   typedef struct packed {
      logic [MAX_CNT_W-1:0] period;
      logic                 enable;
      logic                 latch;
   } chan_cfg_t;

   // Channel address width; a single channel still gets a 1-bit address.
   function automatic int ch_aw(input int n_ch);
      return (n_ch <= 1) ? 1 : $clog2(n_ch);
   endfunction

endpackage

// File: rtl/picorv32_irq_timer_chan.sv
// One timer channel: period/enable/mode registers, free-running counter,
// pending latch and sticky overrun flag. The config write takes priority over counting.
module picorv32_irq_timer_chan
   import picorv32_irq_timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      cfg_wr,
   input  chan_cfg_t cfg,
   input  logic      eoi,
   output logic      irq,
   output logic      overrun
);

   generate
      if (CNT_W < 2 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
         $error("picorv32_irq_timer_chan: CNT_W must be in 2..32");
      end
   endgenerate

   logic [CNT_W-1:0] period_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             enable_reg;
   logic             latch_reg;
   logic             pending_reg;
   logic             pending_next;
   logic             irq_reg;
   logic             irq_next;
   logic             overrun_reg;
   logic             overrun_next;
   logic             active;
   logic             terminal;
   logic             unused_cfg;

   // Only the low CNT_W bits of the period field are meaningful here.
   assign unused_cfg = ^cfg.period;

   assign active   = enable_reg && (period_reg != '0);
   assign terminal = active && (cnt_reg == (period_reg - CNT_W'(1)));

   always_comb begin
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      overrun_next = overrun_reg;
      irq_next     = 1'b0;

      if (!active) begin
         cnt_next = '0;
      end else if (terminal) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end

      if (latch_reg == MODE_LATCH) begin
         // A fire coinciding with eoi re-arms pending without counting as missed.
         pending_next = terminal | (pending_reg & ~eoi);
         overrun_next = overrun_reg | (terminal & pending_reg & ~eoi);
         irq_next     = pending_next;
      end else begin
         pending_next = 1'b0;
         overrun_next = overrun_reg;
         irq_next     = terminal;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         period_reg  <= '0;
         enable_reg  <= 1'b0;
         latch_reg   <= MODE_PULSE;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
         irq_reg     <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (cfg_wr) begin
         period_reg  <= cfg.period[CNT_W-1:0];
         enable_reg  <= cfg.enable;
         latch_reg   <= cfg.latch;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
         irq_reg     <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         irq_reg     <= irq_next;
         overrun_reg <= overrun_next;
      end
   end

   assign irq     = irq_reg;
   assign overrun = overrun_reg;

endmodule

// File: rtl/picorv32_irq_timer.sv
// N_CH-channel periodic interrupt generator for the picorv32 irq input.
// Decodes config writes to channels and places channel irqs at irq[IRQ_BASE+i].
module picorv32_irq_timer
   import picorv32_irq_timer_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int CNT_W    = 16,
   parameter int IRQ_BASE = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ch_aw(N_CH)-1:0]   cfg_chan,
   input  logic [CNT_W-1:0]         cfg_period,
   input  logic                     cfg_enable,
   input  logic                     cfg_latch,
   input  logic [31:0]              eoi,
   output logic [31:0]              irq,
   output logic [N_CH-1:0]          overrun
);

   localparam int CH_AW = ch_aw(N_CH);

   generate
      if (N_CH < 1 || N_CH > 32 || IRQ_BASE < 0 || IRQ_BASE + N_CH > 32) begin : g_bad_params
         $error("picorv32_irq_timer: need 1 <= N_CH <= 32 and IRQ_BASE + N_CH <= 32");
      end
   endgenerate

   logic            cfg_ready_reg;
   logic            cfg_accept;
   chan_cfg_t       cfg_s;
   logic [N_CH-1:0] cfg_wr_vec;
   logic [N_CH-1:0] irq_ch;
   logic            unused_eoi;

   // Channels only look at their own eoi bit.
   assign unused_eoi = ^eoi;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cfg_ready_reg <= 1'b0;
      end else begin
         cfg_ready_reg <= 1'b1;
      end
   end

   assign cfg_ready  = cfg_ready_reg;
   assign cfg_accept = cfg_valid & cfg_ready_reg;

   always_comb begin
      cfg_s                    = '0;
      cfg_s.period[CNT_W-1:0]  = cfg_period;
      cfg_s.enable             = cfg_enable;
      cfg_s.latch              = cfg_latch;
   end

   genvar gi;

   // Out-of-range channel numbers match no decoder and are silently accepted.
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_chan
         assign cfg_wr_vec[gi] = cfg_accept && (cfg_chan == CH_AW'(gi));

         picorv32_irq_timer_chan #(
            .CNT_W (CNT_W)
         ) u_chan (
            .clk     (clk),
            .resetn  (resetn),
            .cfg_wr  (cfg_wr_vec[gi]),
            .cfg     (cfg_s),
            .eoi     (eoi[IRQ_BASE+gi]),
            .irq     (irq_ch[gi]),
            .overrun (overrun[gi])
         );
      end
   endgenerate

   generate
      for (gi = 0; gi < 32; gi++) begin : g_irq_map
         if (gi >= IRQ_BASE && gi < IRQ_BASE + N_CH) begin : g_used
            assign irq[gi] = irq_ch[gi-IRQ_BASE];
         end else begin : g_tied
            assign irq[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: doc/picorv32_irq_timer.md
Name: picorv32_irq_timer

Overview:
Parametrised periodic interrupt generator for the picorv32 core's 32-bit irq input. It is the next generation of the fixed cycle-count-bit IRQ taps used in the core test tops. It provides N_CH independent channels, each with a programmable period, enable, and latched-or-pulse mode. Pending interrupts are cleared by the core's eoi vector, and missed interrupts are flagged as overruns.

Parameters:
N_CH, 2, number of timer channels (1..32)
CNT_W, 16, width of period and counter per channel (2..32)
IRQ_BASE, 4, irq bit driven by channel 0; channel i drives irq[IRQ_BASE+i]; IRQ_BASE+N_CH <= 32 is enforced by elaboration assertion

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  synchronous reset, active low
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high together with cfg_valid
cfg_chan  in  CH_AW  target channel, CH_AW = max(1,$clog2(N_CH))
cfg_period  in  CNT_W  period in cycles; 0 = channel stopped
cfg_enable  in  1  channel enable
cfg_latch  in  1  1 = latched (held until eoi), 0 = one-cycle pulse
eoi  in  32  end-of-interrupt from core; bit IRQ_BASE+i clears channel i
irq  out  32  registered interrupt vector to core; bits outside channel range tied 0
overrun  out  N_CH  sticky per-channel missed-interrupt flag

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-low.
- Reset (resetn low at an edge):
  - All channels disabled; period 0; latch mode 0; counters 0.
  - Pending, irq and overrun all 0.
  - cfg_ready = 0 while resetn is low, 1 otherwise.
- Config accept: a write is accepted at an edge where cfg_valid & cfg_ready.
  - For cfg_chan < N_CH, the write loads period, enable and latch; clears that channel's counter, pending, irq bit and overrun.
  - For cfg_chan >= N_CH, the write is accepted and has no effect.
  - Other channels are unaffected.
- Counting: a channel is active iff enable=1 and period!=0.
  - When active, the counter increments each edge.
  - When counter == period-1 at an edge ("terminal"), the counter wraps to 0 and the channel fires.
  - When inactive, the counter holds at 0.
- Latency: first fire occurs on the P-th edge after the accept edge; irq is visible in the cycle that follows.
  - Subsequent fires occur every P edges.
  - P=1 fires every edge.
  - Counter width wrap: period = 2^CNT_W-1 is the maximum.
- Latched mode:
  - Fire sets pending; irq bit = pending (registered).
  - eoi bit high at an edge clears pending.
  - Fire while pending is already set and eoi is not high: pending stays 1, overrun is set (sticky until a config write or reset).
  - Fire and eoi in the same edge: pending stays 1, no overrun.
- Pulse mode:
  - irq bit high for exactly one cycle after each fire edge.
  - eoi is ignored; overrun is never set.
- Disable by config write mid-count: counter resets and pending clears at the accept edge; no fire occurs on that edge even if the old counter was terminal.
- Mode change takes effect from the accept edge; no glitch pulse is allowed.
- All outputs are registered; there is no combinational path from eoi or cfg_* to irq.

Decomposition:
- Package picorv32_irq_timer_pkg:
  - CH_AW computation function.
  - Channel config struct {period, enable, latch}.
  - Mode constants MODE_PULSE = 0, MODE_LATCH = 1.
- Sub-module picorv32_irq_timer_chan:
  - One instance per channel.
  - Holds config, counter, pending and overrun.
  - Inputs: cfg_wr strobe, cfg struct, eoi bit.
  - Outputs: irq bit, overrun bit.
- The top does address decode, generate loop and irq vector placement.

Test Plan:
- Reset then idle 100 cycles -> irq == 0, overrun == 0, cfg_ready == 1 from the first edge after resetn high.
- Channel 0, period 8192, latch, no eoi -> irq[4] rises 8192 edges after accept; overrun[0] sets at edge 16384; irq[4] stays high.
- Channel 1, period 5, pulse mode -> irq[5] is a one-cycle pulse every 5 cycles, 10 pulses in 50 cycles; eoi[5] has no effect.
- Channel 0, period 3, latch; eoi[4] asserted on the same edge as each fire -> irq[4] stays 1, overrun[0] stays 0; eoi asserted 1 cycle after irq rises -> irq[4] low for 2 cycles per period.
- Mid-count rewrite of channel 0 to period 0 at counter == period-1 -> no fire, irq[4] clears the next cycle; cfg_chan = 3 with N_CH=2 -> no state change.
- resetn pulled low for 1 cycle while both channels are pending -> irq, overrun and counters are 0 the next cycle, and no fire occurs until reconfigured.
